// File: rtl/lc3_control_unit.sv
// lc3_control_unit
// Moore control FSM for the LC-3 datapath. Sequences instruction fetch,
// decode and execution of ADD, AND, NOT, LD, ST, BR and LEA. TRAP halts the
// machine until reset, and every other opcode executes as a NOP.
//
// Ports:
//   i_CLK, i_RST_N        clock and synchronous active-low reset
//   i_IR[15:0]            instruction register (opcode [15:12], BR nzp [11:9])
//   i_N, i_Z, i_P         condition codes, used only in BR0
//   i_MEM_R               memory ready, completes the current access
//   o_LD_*                register load enables
//   o_GATE_*              bus drivers (at most one is high in any state)
//   o_ALUK, o_SR1MUX,
//   o_DRMUX, o_PCMUX,
//   o_MIO_EN              datapath mux selects
//   o_MEM_EN, o_MEM_WE    memory request and write strobe
//   o_HALTED              high in HALT
//   o_STATE[3:0]          current state encoding, for debug
module lc3_control_unit (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic [15:0] i_IR,
  input  logic        i_N,
  input  logic        i_Z,
  input  logic        i_P,
  input  logic        i_MEM_R,
  output logic        o_LD_REG,
  output logic        o_LD_CC,
  output logic        o_LD_IR,
  output logic        o_LD_PC,
  output logic        o_LD_MAR,
  output logic        o_LD_MDR,
  output logic        o_GATE_ALU,
  output logic        o_GATE_PC,
  output logic        o_GATE_MDR,
  output logic        o_GATE_MARMUX,
  output logic [1:0]  o_ALUK,
  output logic [1:0]  o_SR1MUX,
  output logic [1:0]  o_DRMUX,
  output logic        o_PCMUX,
  output logic        o_MIO_EN,
  output logic        o_MEM_EN,
  output logic        o_MEM_WE,
  output logic        o_HALTED,
  output logic [3:0]  o_STATE
);

  typedef enum logic [3:0] {
    S_FETCH0 = 4'd0,  S_FETCH1 = 4'd1,  S_FETCH2 = 4'd2,  S_DECODE = 4'd3,
    S_ALU    = 4'd4,  S_LEA    = 4'd5,  S_LD0    = 4'd6,  S_LD1    = 4'd7,
    S_LD2    = 4'd8,  S_ST0    = 4'd9,  S_ST1    = 4'd10, S_ST2    = 4'd11,
    S_BR0    = 4'd12, S_BR1    = 4'd13, S_HALT   = 4'd14
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  opcode_s;
  logic        br_taken_s;
  // The offset field is consumed by the datapath's address adder, not here.
  logic        unused_ir_bits_s;

  assign opcode_s         = i_IR[15:12];
  assign br_taken_s       = (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P);
  assign unused_ir_bits_s = ^i_IR[8:0];

  // State register with synchronous active-low reset.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= S_FETCH0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = i_MEM_R ? S_FETCH2 : S_FETCH1;
      S_FETCH2: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_s)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
          4'b0010: state_d = S_LD0;
          4'b0011: state_d = S_ST0;
          4'b0000: state_d = S_BR0;
          4'b1110: state_d = S_LEA;
          4'b1111: state_d = S_HALT;
          default: state_d = S_FETCH0;
        endcase
      end
      S_ALU:    state_d = S_FETCH0;
      S_LEA:    state_d = S_FETCH0;
      S_LD0:    state_d = S_LD1;
      S_LD1:    state_d = i_MEM_R ? S_LD2 : S_LD1;
      S_LD2:    state_d = S_FETCH0;
      S_ST0:    state_d = S_ST1;
      S_ST1:    state_d = S_ST2;
      S_ST2:    state_d = i_MEM_R ? S_FETCH0 : S_ST2;
      S_BR0:    state_d = br_taken_s ? S_BR1 : S_FETCH0;
      S_BR1:    state_d = S_FETCH0;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH0;
    endcase
  end

  // Moore output decode; reset forces every output low in the same cycle.
  always_comb begin
    o_LD_REG      = 1'b0;
    o_LD_CC       = 1'b0;
    o_LD_IR       = 1'b0;
    o_LD_PC       = 1'b0;
    o_LD_MAR      = 1'b0;
    o_LD_MDR      = 1'b0;
    o_GATE_ALU    = 1'b0;
    o_GATE_PC     = 1'b0;
    o_GATE_MDR    = 1'b0;
    o_GATE_MARMUX = 1'b0;
    o_ALUK        = 2'b00;
    o_SR1MUX      = 2'b00;
    o_DRMUX       = 2'b00;
    o_PCMUX       = 1'b0;
    o_MIO_EN      = 1'b0;
    o_MEM_EN      = 1'b0;
    o_MEM_WE      = 1'b0;
    o_HALTED      = 1'b0;
    o_STATE       = 4'd0;
    if (i_RST_N) begin
      o_STATE = state_q;
      case (state_q)
        S_FETCH0: begin
          o_GATE_PC = 1'b1;
          o_LD_MAR  = 1'b1;
          o_LD_PC   = 1'b1;
        end
        S_FETCH1, S_LD1: begin
          o_MEM_EN = 1'b1;
          o_MIO_EN = 1'b1;
          o_LD_MDR = 1'b1;
        end
        S_FETCH2: begin
          o_GATE_MDR = 1'b1;
          o_LD_IR    = 1'b1;
        end
        S_ALU: begin
          o_GATE_ALU = 1'b1;
          o_LD_REG   = 1'b1;
          o_LD_CC    = 1'b1;
          o_SR1MUX   = 2'b01;
          // ALU op follows the opcode still held in IR.
          case (opcode_s)
            4'b0101: o_ALUK = 2'b01;
            4'b1001: o_ALUK = 2'b10;
            default: o_ALUK = 2'b00;
          endcase
        end
        S_LEA: begin
          o_GATE_MARMUX = 1'b1;
          o_LD_REG      = 1'b1;
        end
        S_LD0, S_ST0: begin
          o_GATE_MARMUX = 1'b1;
          o_LD_MAR      = 1'b1;
        end
        S_LD2: begin
          o_GATE_MDR = 1'b1;
          o_LD_REG   = 1'b1;
          o_LD_CC    = 1'b1;
        end
        S_ST1: begin
          // Store data is passed through the ALU from SR = IR[11:9].
          o_SR1MUX   = 2'b00;
          o_ALUK     = 2'b11;
          o_GATE_ALU = 1'b1;
          o_LD_MDR   = 1'b1;
        end
        S_ST2: begin
          o_MEM_EN = 1'b1;
          o_MEM_WE = 1'b1;
        end
        S_BR1: begin
          o_LD_PC = 1'b1;
          o_PCMUX = 1'b1;
        end
        S_HALT: o_HALTED = 1'b1;
        default: o_STATE = state_q;
      endcase
    end else begin
      o_STATE = 4'd0;
    end
  end

endmodule
